// File: rtl/operand_fwd_stage.sv
// -----------------------------------------------------------------------------
// operand_fwd_stage
//
// Purpose:
//   The operand-selection and forwarding stage between decode and execute.
//   Each of NUM_OPS operands takes one of four sources: the immediate, x0
//   (always zero), a forwarded result from a later pipeline stage, or
//   register-file data. Among the forwarding sources, index 0 is the youngest
//   and has the highest priority.
//   A load-use hazard is flagged when the youngest matching source does not
//   yet have its data. In that case a bubble is inserted into the ID/EX
//   register. A saturating 16-bit counter records how many operands were
//   forwarded.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   valid_i        decode presents an instruction
//   ready_o        instruction accepted this cycle (~stall & ~hazard)
//   rs_addr_i      per-operand source register address
//   rf_data_i      per-operand register-file read data
//   imm_i          immediate shared by all operands
//   imm_sel_i      per-operand immediate select
//   src_we_i       per-source write enable
//   src_rd_i       per-source destination address
//   src_data_i     per-source result data
//   src_rdy_i      per-source data-valid (0 = load in flight)
//   stall_i        execute cannot take new data
//   flush_i        kill contents of this stage
//   op_data_o      registered operands
//   op_valid_o     registered operands valid
//   fwd_sel_o      registered select codes
//                  (0 = RF, k+1 = source k, NUM_SRC+1 = immediate)
//   hazard_o       combinational load-use hazard
//   fwd_count_o    saturating forwarded-operand count
// -----------------------------------------------------------------------------
module operand_fwd_stage #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_OPS = 2,
  parameter int NUM_SRC = 2,
  parameter int SELW    = $clog2(NUM_SRC + 2)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [NUM_OPS*AW-1:0]    rs_addr_i,
  input  logic [NUM_OPS*XLEN-1:0]  rf_data_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [NUM_OPS-1:0]       imm_sel_i,
  input  logic [NUM_SRC-1:0]       src_we_i,
  input  logic [NUM_SRC*AW-1:0]    src_rd_i,
  input  logic [NUM_SRC*XLEN-1:0]  src_data_i,
  input  logic [NUM_SRC-1:0]       src_rdy_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [NUM_OPS*XLEN-1:0]  op_data_o,
  output logic                     op_valid_o,
  output logic [NUM_OPS*SELW-1:0]  fwd_sel_o,
  output logic                     hazard_o,
  output logic [15:0]              fwd_count_o
);

  localparam logic [SELW-1:0] CODE_IMM = SELW'(NUM_SRC + 1);
  localparam int              ADDW     = $clog2(NUM_OPS + 1);

  logic [NUM_OPS*XLEN-1:0] res_data;
  logic [NUM_OPS*SELW-1:0] res_sel;
  logic [NUM_OPS-1:0]      op_hazard;
  logic [NUM_OPS-1:0]      op_fwd;

  // Per-operand resolution
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
      logic [AW-1:0]   rs;
      logic [XLEN-1:0] data;
      logic [SELW-1:0] sel;
      logic            hz;
      logic            fwd;

      assign rs = rs_addr_i[gi*AW +: AW];

      always_comb begin
        data = rf_data_i[gi*XLEN +: XLEN];
        sel  = '0;
        hz   = 1'b0;
        fwd  = 1'b0;
        if (imm_sel_i[gi]) begin
          data = imm_i;
          sel  = CODE_IMM;
        end else if (rs == '0) begin
          data = '0;
        end else begin
          // Walk from oldest to youngest so the youngest match is written
          // last. Only that match's ready bit decides the hazard; older
          // matches are ignored, even when they are ready.
          for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (src_we_i[k] && (src_rd_i[k*AW +: AW] == rs)) begin
              data = src_data_i[k*XLEN +: XLEN];
              sel  = SELW'(k + 1);
              hz   = ~src_rdy_i[k];
              fwd  = 1'b1;
            end
          end
        end
      end

      assign res_data[gi*XLEN +: XLEN] = data;
      assign res_sel[gi*SELW +: SELW]  = sel;
      assign op_hazard[gi]             = hz;
      assign op_fwd[gi]                = fwd;
    end
  endgenerate

  logic accept;

  assign hazard_o = valid_i & (|op_hazard);
  assign ready_o  = ~stall_i & ~hazard_o;
  assign accept   = valid_i & ready_o;

  // Number of operands forwarded in this transfer
  logic [ADDW-1:0] fwd_add;
  always_comb begin
    fwd_add = '0;
    for (int n = 0; n < NUM_OPS; n++) begin
      if (op_fwd[n]) fwd_add = fwd_add + ADDW'(1);
    end
  end

  logic [15:0] cnt_reg, cnt_next;
  logic [16:0] cnt_sum;

  // The 17-bit sum exposes any overflow in bit 16, so the count clamps at
  // 0xFFFF instead of wrapping.
  assign cnt_sum  = {1'b0, cnt_reg} + 17'(fwd_add);
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  logic [NUM_OPS*XLEN-1:0] op_data_reg;
  logic [NUM_OPS*SELW-1:0] fwd_sel_reg;
  logic                    op_valid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_data_reg  <= '0;
      fwd_sel_reg  <= '0;
      op_valid_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (flush_i) begin
      // A flush kills the stage even while stalled. New data is captured
      // only when the stage is not frozen. The count is not incremented.
      op_valid_reg <= 1'b0;
      if (!stall_i) begin
        op_data_reg <= res_data;
        fwd_sel_reg <= res_sel;
      end
    end else if (stall_i) begin
      // hold everything, including op_valid
    end else if (hazard_o) begin
      op_valid_reg <= 1'b0;
    end else begin
      op_valid_reg <= valid_i;
      if (accept) begin
        op_data_reg <= res_data;
        fwd_sel_reg <= res_sel;
        cnt_reg     <= cnt_next;
      end
    end
  end

  assign op_data_o   = op_data_reg;
  assign fwd_sel_o   = fwd_sel_reg;
  assign op_valid_o  = op_valid_reg;
  assign fwd_count_o = cnt_reg;

endmodule

// File: tb/tb_operand_fwd_stage.sv
module tb_operand_fwd_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [9:0]  rs_addr_i;
  logic [63:0] rf_data_i;
  logic [31:0] imm_i;
  logic [1:0]  imm_sel_i;
  logic [1:0]  src_we_i;
  logic [9:0]  src_rd_i;
  logic [63:0] src_data_i;
  logic [1:0]  src_rdy_i;
  logic        stall_i;
  logic        flush_i;
  logic [63:0] op_data_o;
  logic        op_valid_o;
  logic [3:0]  fwd_sel_o;
  logic        hazard_o;
  logic [15:0] fwd_count_o;

  operand_fwd_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rs_addr_i(rs_addr_i), .rf_data_i(rf_data_i), .imm_i(imm_i),
    .imm_sel_i(imm_sel_i), .src_we_i(src_we_i), .src_rd_i(src_rd_i),
    .src_data_i(src_data_i), .src_rdy_i(src_rdy_i), .stall_i(stall_i),
    .flush_i(flush_i), .op_data_o(op_data_o), .op_valid_o(op_valid_o),
    .fwd_sel_o(fwd_sel_o), .hazard_o(hazard_o), .fwd_count_o(fwd_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [4:0]  rs0, rs1;
    logic [31:0] rf0, rf1, imm;
    logic [1:0]  isel, we;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
    logic        stall, flush;
    logic        e_hz, e_rdy, e_ov;
    logic [31:0] e_op0, e_op1;
    logic [3:0]  e_sel;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_i    = t.v;
    rs_addr_i  = {t.rs1, t.rs0};
    rf_data_i  = {t.rf1, t.rf0};
    imm_i      = t.imm;
    imm_sel_i  = t.isel;
    src_we_i   = t.we;
    src_rd_i   = {t.rd1, t.rd0};
    src_data_i = {t.d1, t.d0};
    src_rdy_i  = t.rdy;
    stall_i    = t.stall;
    flush_i    = t.flush;
  endtask

  task automatic chk_regs(input string tag, input logic ov, input logic [31:0] op0,
                          input logic [31:0] op1, input logic [3:0] sel, input logic [15:0] cnt);
    chk({tag, ".op_valid"}, 32'(op_valid_o), 32'(ov));
    chk({tag, ".op0"}, op_data_o[31:0], op0);
    chk({tag, ".op1"}, op_data_o[63:32], op1);
    chk({tag, ".fwd_sel"}, 32'(fwd_sel_o), 32'(sel));
    chk({tag, ".fwd_count"}, 32'(fwd_count_o), 32'(cnt));
  endtask

  // Step one cycle: comb checks before the edge, register checks just after
  task automatic step(input string tag, input logic e_hz, input logic e_rdy);
    #3;
    chk({tag, ".hazard"}, 32'(hazard_o), 32'(e_hz));
    chk({tag, ".ready"}, 32'(ready_o), 32'(e_rdy));
    @(posedge clk_i); #1;
  endtask

  vec_t base;

  initial begin
    // Table layout: v rs0 rs1 rf0 rf1 imm isel we rd0 rd1 d0 d1 rdy stall flush
    //               | hz rdy ov op0 op1 sel cnt
    tbl[0]  = '{1, 1, 2, 32'h100, 32'h200, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0,
                0, 1, 1, 32'h100, 32'h200, 4'b0000, 16'd0};
    tbl[1]  = '{1, 5, 2, 32'h100, 32'h200, 0, 2'b00, 2'b11, 5, 5, 32'hAAAA0000, 32'h11111111, 2'b11, 0, 0,
                0, 1, 1, 32'hAAAA0000, 32'h200, 4'b0001, 16'd1};
    tbl[2]  = '{1, 5, 2, 32'h100, 32'h200, 0, 2'b00, 2'b10, 5, 5, 32'hAAAA0000, 32'h11111111, 2'b11, 0, 0,
                0, 1, 1, 32'h11111111, 32'h200, 4'b0010, 16'd2};
    tbl[3]  = '{1, 0, 3, 32'h100, 32'h200, 32'h7FF, 2'b10, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 2'b11, 0, 0,
                0, 1, 1, 32'h0, 32'h7FF, 4'b1100, 16'd2};
    tbl[4]  = '{1, 6, 2, 32'h100, 32'h200, 0, 2'b00, 2'b11, 6, 6, 1, 2, 2'b10, 0, 0,
                1, 0, 0, 32'h0, 32'h7FF, 4'b1100, 16'd2};
    tbl[5]  = '{0, 6, 2, 32'h100, 32'h200, 0, 2'b00, 2'b11, 6, 6, 1, 2, 2'b10, 0, 0,
                0, 1, 0, 32'h0, 32'h7FF, 4'b1100, 16'd2};
    tbl[6]  = '{1, 8, 9, 32'h100, 32'h200, 0, 2'b00, 2'b11, 8, 9, 32'hA, 32'hB, 2'b11, 0, 0,
                0, 1, 1, 32'hA, 32'hB, 4'b1001, 16'd4};
    tbl[7]  = '{1, 8, 9, 32'h100, 32'h200, 0, 2'b00, 2'b11, 8, 9, 32'hA, 32'hB, 2'b11, 1, 0,
                0, 0, 1, 32'hA, 32'hB, 4'b1001, 16'd4};
    tbl[8]  = '{1, 8, 9, 32'h100, 32'h200, 0, 2'b00, 2'b11, 8, 9, 32'hA, 32'hB, 2'b00, 1, 0,
                1, 0, 1, 32'hA, 32'hB, 4'b1001, 16'd4};
    tbl[9]  = '{1, 1, 2, 32'h100, 32'h200, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 1, 1,
                0, 0, 0, 32'hA, 32'hB, 4'b1001, 16'd4};
    tbl[10] = '{1, 8, 2, 32'h100, 32'h200, 0, 2'b00, 2'b01, 8, 0, 32'hC, 0, 2'b11, 0, 1,
                0, 1, 0, 32'hC, 32'h200, 4'b0001, 16'd4};
    tbl[11] = '{1, 1, 7, 32'h100, 32'h200, 0, 2'b00, 2'b01, 7, 0, 32'hC, 0, 2'b00, 0, 0,
                1, 0, 0, 32'hC, 32'h200, 4'b0001, 16'd4};

    // Reset for 2 cycles with a forwardable, valid instruction present
    drive(tbl[1]);
    rst_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk_regs("reset", 0, 0, 0, 4'b0000, 16'd0);
    $display("txn reset: op_valid=%0d fwd_count=%0d", op_valid_o, fwd_count_o);
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      step($sformatf("vec%0d", i), tbl[i].e_hz, tbl[i].e_rdy);
      chk_regs($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_op0, tbl[i].e_op1,
               tbl[i].e_sel, tbl[i].e_cnt);
      $display("txn vec%0d: op0=0x%08h op1=0x%08h sel=%b valid=%0d count=%0d",
               i, op_data_o[31:0], op_data_o[63:32], fwd_sel_o, op_valid_o, fwd_count_o);
    end

    // Load-use: rs1=7 waits on src0 for two cycles, then data arrives
    base = tbl[11];
    drive(base);
    for (int c = 0; c < 2; c++) begin
      step($sformatf("lu_wait%0d", c), 1'b1, 1'b0);
      chk($sformatf("lu_wait%0d.op_valid", c), 32'(op_valid_o), 32'd0);
    end
    base.rdy = 2'b11;
    base.d0  = 32'h1234;
    drive(base);
    step("lu_go", 1'b0, 1'b1);
    chk_regs("lu_go", 1, 32'h100, 32'h1234, 4'b0100, 16'd5);
    $display("txn load-use: op1=0x%08h valid=%0d", op_data_o[63:32], op_valid_o);

    // Stall three cycles with a new instruction waiting: outputs frozen
    base = tbl[6];
    base.stall = 1'b1;
    drive(base);
    for (int c = 0; c < 3; c++) begin
      step($sformatf("stall%0d", c), 1'b0, 1'b0);
      chk_regs($sformatf("stall%0d", c), 1, 32'h100, 32'h1234, 4'b0100, 16'd5);
    end
    $display("txn stall: op_valid=%0d count=%0d", op_valid_o, fwd_count_o);

    // Flush together with stall: invalidated, data and counter held
    base.flush = 1'b1;
    drive(base);
    step("flush_stall", 1'b0, 1'b0);
    chk_regs("flush_stall", 0, 32'h100, 32'h1234, 4'b0100, 16'd5);
    $display("txn flush+stall: op_valid=%0d count=%0d", op_valid_o, fwd_count_o);

    // Reset while a hazard is pending clears everything
    drive(tbl[11]);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk_regs("rst_hazard", 0, 0, 0, 4'b0000, 16'd0);
    step("post_rst_hazard", 1'b1, 1'b0);
    $display("txn reset mid-hazard: count=%0d", fwd_count_o);

    // Counter saturation: 32767 two-operand forwards reach 0xFFFE
    drive(tbl[6]);
    for (int c = 0; c < 32767; c++) begin
      @(posedge clk_i);
    end
    #1;
    chk("sat_pre.fwd_count", 32'(fwd_count_o), 32'h0000FFFE);
    base = tbl[6];
    base.rs1 = 5'd2;
    drive(base);
    @(posedge clk_i); #1;
    chk("sat_one.fwd_count", 32'(fwd_count_o), 32'h0000FFFF);
    drive(tbl[6]);
    @(posedge clk_i); #1;
    chk("sat_hold.fwd_count", 32'(fwd_count_o), 32'h0000FFFF);
    chk("sat_hold.op_valid", 32'(op_valid_o), 32'd1);
    $display("txn saturation: count=0x%04h", fwd_count_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fwd_stage.md
# operand_fwd_stage

Parametrised operand-selection and forwarding stage between decode and execute of the RISC-V-lite pipeline. For each of NUM_OPS operands it resolves register-file, forwarded or immediate data, with address-compare-based forwarding from NUM_SRC later pipeline stages (youngest wins). It detects load-use hazards and registers the result into the ID/EX boundary with stall, flush and bubble insertion. It also keeps a saturating forwarding-event counter.

## Interface
- XLEN, 32, operand data width
- AW, 5, register address width
- NUM_OPS, 2, number of operands resolved per instruction
- NUM_SRC, 2, forwarding sources; index 0 = youngest (EX/MEM), higher = older (MEM/WB, ...)
- SELW, $clog2(NUM_SRC+2), width of one select code
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  decode stage presents an instruction
- ready_o  out  1  stage accepts the instruction this cycle
- rs_addr_i  in  NUM_OPS*AW  source register address per operand, operand n at [n*AW +: AW]
- rf_data_i  in  NUM_OPS*XLEN  register-file read data per operand
- imm_i  in  XLEN  immediate shared by all operands
- imm_sel_i  in  NUM_OPS  1 = operand n takes imm_i
- src_we_i  in  NUM_SRC  source k will write rd
- src_rd_i  in  NUM_SRC*AW  destination address of source k
- src_data_i  in  NUM_SRC*XLEN  result data of source k
- src_rdy_i  in  NUM_SRC  source k data is valid (0 = load still in flight)
- stall_i  in  1  execute stage cannot take new data
- flush_i  in  1  kill contents of this stage
- op_data_o  out  NUM_OPS*XLEN  registered operands
- op_valid_o  out  1  registered operands valid
- fwd_sel_o  out  NUM_OPS*SELW  registered select code per operand: 0 = register file, k+1 = source k, NUM_SRC+1 = immediate
- hazard_o  out  1  combinational load-use hazard flag
- fwd_count_o  out  16  saturating count of forwarded operands

## Operation
- Per operand n, combinational priority:
  1. imm_sel_i[n] → imm_i, code NUM_SRC+1.
  2. rs_addr == 0 → data 0, code 0. x0 is never forwarded, never hazards.
  3. Lowest k with src_we_i[k] & src_rd_i[k]==rs_addr → src_data_i[k], code k+1. A hazard is flagged if src_rdy_i[k]==0. Older matches are ignored even if ready.
  4. Otherwise → rf_data_i[n], code 0.
- hazard_o = valid_i & OR of per-operand hazards.
- ready_o = ~stall_i & ~hazard_o. It is independent of flush_i.
- Accept = valid_i & ready_o.
- Register update, in priority order:
  - rst_i: op_data_o=0, op_valid_o=0, fwd_sel_o=0, fwd_count_o=0.
  - flush_i: op_valid_o=0. Data and select are loaded if not stalled, otherwise held. The counter is not incremented. Flush overrides stall.
  - stall_i: all outputs held.
  - hazard_o: bubble. op_valid_o=0, data and select held, counter held.
  - Otherwise: op_valid_o=valid_i. When accepted, op_data_o and fwd_sel_o load the resolved values.
- Counter:
  - On each accepted, non-flushed transfer, add the number of operands with code in 1..NUM_SRC.
  - Saturates at 0xFFFF; never wraps.
  - Add width covers NUM_OPS before saturation.

## Timing
- Operand resolution, hazard_o and ready_o are combinational from inputs in the same cycle.
- Outputs are valid 1 cycle after acceptance.
- Throughput is one instruction per cycle when there is no stall or hazard.
- A hazard holds ready_o low each cycle until src_rdy_i rises. On that cycle the instruction is accepted and forwarded data is registered.
- Reset applied mid-stall or mid-hazard clears all state on the next edge. ready_o then follows the inputs.
- Simultaneous stall_i and hazard: outputs are held (stall wins over bubble). op_valid_o keeps its previous value.

## Test plan
- Reset: assert rst_i 2 cycles with valid_i=1 → op_valid_o=0, op_data_o=0, fwd_sel_o=0, fwd_count_o=0 after the edge.
- Forwarding priority: rs0=5, src0 rd=5 data=0xAAAA0000, src1 rd=5 data=0x11111111, both ready → op0=0xAAAA0000, code 1, count +1. Then src0_we=0 → op0=0x11111111, code 2.
- x0 and immediate: rs0=0 with src0 rd=0 data=0xFFFFFFFF, imm_sel[1]=1, imm=0x7FF → op0=0, code 0, op1=0x7FF, code 3, count +0.
- Load-use: rs1=7 matches src0 with src_rdy=0 for 2 cycles → hazard_o=1, ready_o=0, op_valid_o=0 for 2 cycles. src_rdy rises with data 0x1234 → accepted, next cycle op1=0x1234, op_valid_o=1.
- Stall and flush: stall_i=1 for 3 cycles → outputs frozen, ready_o=0. flush_i with stall_i → op_valid_o=0 next cycle, count unchanged.
- Counter saturation: preload via 0xFFFF forwarded transfers (or 32767 two-operand transfers plus one single), then one two-operand forward → fwd_count_o stays 0xFFFF.
